// File: rtl/conway_mode_controller_pkg.sv
// conway_mode_controller_pkg: command/state encodings and counter sizing shared by the mode controller
package conway_mode_controller_pkg;

    typedef enum logic [1:0] {CMD_NOP, CMD_LOAD, CMD_RUN, CMD_OUTPUT} cmd_e;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_OUTPUT} state_e;

    function automatic int cnt_width(input int data_size, input int gen_width);
        return ($clog2(data_size + 1) > gen_width) ? $clog2(data_size + 1) : gen_width;
    endfunction

endpackage

// File: rtl/conway_mode_controller.sv
// conway_mode_controller: sequences load/run/output modes of the system memory from host commands
module conway_mode_controller
    import conway_mode_controller_pkg::*;
#(
    parameter int DATA_SIZE = 25,
    parameter int GEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           cmd,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [GEN_WIDTH-1:0] generations,
    input  logic                 abort,
    input  logic                 load_data,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic                 out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 load_mode,
    output logic                 run_mode,
    output logic                 output_mode,
    output logic                 serial_in,
    input  logic                 serial_out,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = cnt_width(DATA_SIZE, GEN_WIDTH);

    state_e        state;
    logic [CW-1:0] cnt;

    // Handshakes and memory modes decode straight from state so the memory sees them in the same cycle;
    // abort kills every mode immediately since the FSM leaves on the coming edge anyway.
    assign cmd_ready   = state == ST_IDLE;
    assign busy        = state != ST_IDLE;
    assign load_ready  = state == ST_LOAD && !abort;
    assign load_mode   = load_ready && load_valid;
    assign serial_in   = state == ST_LOAD && load_data;
    assign run_mode    = state == ST_RUN && !abort;
    assign output_mode = state == ST_OUTPUT && !abort && cnt != '0 && (!out_valid || out_ready);
    assign out_data    = out_valid && serial_out;

    // Command FSM with the shared down-counter; the memory only shifts on output_mode, so a held
    // out_valid keeps serial_out stable until the host takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else if (abort && state != ST_IDLE) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_e'(cmd))
                            CMD_LOAD: begin
                                state <= ST_LOAD;
                                cnt   <= CW'(DATA_SIZE);
                            end
                            CMD_OUTPUT: begin
                                state <= ST_OUTPUT;
                                cnt   <= CW'(DATA_SIZE);
                            end
                            CMD_RUN: begin
                                if (generations != '0) begin
                                    state <= ST_RUN;
                                    cnt   <= CW'(generations);
                                end else begin
                                    done <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (output_mode) begin
                        cnt       <= cnt - CW'(1);
                        out_valid <= 1'b1;
                    end else if (cnt == '0 && out_valid && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conway_mode_controller.sv
// tb_conway_mode_controller: directed checks of the mode controller against a small shift-register memory model
module tb_conway_mode_controller
    import conway_mode_controller_pkg::*;
();

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] generations;
    logic       abort;
    logic       load_data;
    logic       load_valid;
    logic       load_ready;
    logic       out_data;
    logic       out_valid;
    logic       out_ready;
    logic       load_mode;
    logic       run_mode;
    logic       output_mode;
    logic       serial_in;
    logic       serial_out;
    logic       done;
    logic       busy;

    int vecs = 0;
    int errs = 0;

    int lm_n = 0;
    int rm_n = 0;
    int om_n = 0;
    int done_n = 0;
    int ov_n = 0;
    int overlap_n = 0;
    bit rx_q[$];

    logic [4:0] mem = 5'b00000;
    logic       mem_so = 1'b0;

    always #5 clk = ~clk;

    conway_mode_controller #(.DATA_SIZE(5), .GEN_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .generations(generations), .abort(abort), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .load_mode(load_mode), .run_mode(run_mode), .output_mode(output_mode), .serial_in(serial_in),
        .serial_out(serial_out), .done(done), .busy(busy)
    );

    // Memory stand-in: load shifts serial_in into the LSB, output rotates the MSB out so contents survive.
    always @(posedge clk) begin
        if (load_mode) mem <= {mem[3:0], serial_in};
        else if (output_mode) begin
            mem    <= {mem[3:0], mem[4]};
            mem_so <= mem[4];
        end
    end
    assign serial_out = mem_so;

    // Mid-cycle observation of pulses and accepted output bits.
    always @(negedge clk) begin
        if (load_mode) lm_n <= lm_n + 1;
        if (run_mode) rm_n <= rm_n + 1;
        if (output_mode) om_n <= om_n + 1;
        if (done) done_n <= done_n + 1;
        if (out_valid) ov_n <= ov_n + 1;
        if (out_valid && out_ready) rx_q.push_back(out_data);
        if (32'(load_mode) + 32'(run_mode) + 32'(output_mode) > 1) overlap_n <= overlap_n + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input cmd_e c);
        cmd = c;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        cmd = CMD_NOP;
    endtask

    task automatic test_reset;
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        vecs++; if ({load_mode, run_mode, output_mode} !== 3'b000) begin errs++; $display("FAIL reset_modes: got %b want 000", {load_mode, run_mode, output_mode}); end
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done); end
        vecs++; if (load_ready !== 1'b0) begin errs++; $display("FAIL reset_load_ready: got %b want 0", load_ready); end
    endtask

    task automatic test_load;
        logic [4:0] pat;
        int lm0;
        int d0;
        pat = 5'b01101;
        lm0 = lm_n;
        d0 = done_n;
        send_cmd(CMD_LOAD);
        for (int i = 4; i >= 0; i--) begin
            load_valid = 1'b0;
            tick;
            vecs++; if (load_ready !== 1'b1) begin errs++; $display("FAIL load_ready bit%0d: got %b want 1", i, load_ready); end
            load_valid = 1'b1;
            load_data = pat[i];
            tick;
        end
        load_valid = 1'b0;
        tick;
        tick;
        vecs++; if (lm_n - lm0 != 5) begin errs++; $display("FAIL load_mode_cycles: got %0d want 5", lm_n - lm0); end
        vecs++; if (mem !== 5'b01101) begin errs++; $display("FAIL load_mem: got %b want 01101", mem); end
        vecs++; if (done_n - d0 != 1) begin errs++; $display("FAIL load_done: got %0d want 1", done_n - d0); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL load_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_output(input bit toggle);
        logic [4:0] pat;
        int om0;
        int d0;
        int ov0;
        int rx0;
        int c;
        pat = 5'b01101;
        om0 = om_n;
        d0 = done_n;
        ov0 = ov_n;
        rx0 = rx_q.size();
        out_ready = 1'b1;
        send_cmd(CMD_OUTPUT);
        c = 0;
        while (done_n == d0 && c < 40) begin
            out_ready = toggle ? (c % 2 == 0) : 1'b1;
            tick;
            c++;
        end
        out_ready = 1'b1;
        tick;
        vecs++; if (done_n - d0 != 1) begin errs++; $display("FAIL out_done tog=%0d: got %0d want 1", toggle, done_n - d0); end
        vecs++; if (rx_q.size() - rx0 != 5) begin errs++; $display("FAIL out_bits tog=%0d: got %0d want 5", toggle, rx_q.size() - rx0); end
        for (int i = 0; i < 5 && rx0 + i < rx_q.size(); i++) begin
            vecs++; if (rx_q[rx0 + i] !== pat[4 - i]) begin errs++; $display("FAIL out_bit%0d tog=%0d: got %b want %b", i, toggle, rx_q[rx0 + i], pat[4 - i]); end
        end
        vecs++; if (om_n - om0 != 5) begin errs++; $display("FAIL out_mode_pulses tog=%0d: got %0d want 5", toggle, om_n - om0); end
        vecs++; if (mem !== 5'b01101) begin errs++; $display("FAIL out_mem tog=%0d: got %b want 01101", toggle, mem); end
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL out_valid_after tog=%0d: got %b want 0", toggle, out_valid); end
        if (!toggle) begin
            vecs++; if (ov_n - ov0 != 5) begin errs++; $display("FAIL out_valid_cycles: got %0d want 5", ov_n - ov0); end
        end
    endtask

    task automatic test_run(input int g);
        int rm0;
        int d0;
        int c;
        rm0 = rm_n;
        d0 = done_n;
        generations = 8'(g);
        send_cmd(CMD_RUN);
        c = 0;
        while (done_n == d0 && c < 300) begin
            tick;
            c++;
        end
        tick;
        vecs++; if (rm_n - rm0 != g) begin errs++; $display("FAIL run_cycles g=%0d: got %0d want %0d", g, rm_n - rm0, g); end
        vecs++; if (done_n - d0 != 1) begin errs++; $display("FAIL run_done g=%0d: got %0d want 1", g, done_n - d0); end
    endtask

    task automatic test_cmd_during_load;
        logic [4:0] pat;
        int rm0;
        int d0;
        pat = 5'b10011;
        rm0 = rm_n;
        d0 = done_n;
        send_cmd(CMD_LOAD);
        cmd = CMD_RUN;
        generations = 8'd4;
        cmd_valid = 1'b1;
        vecs++; if (cmd_ready !== 1'b0) begin errs++; $display("FAIL busy_cmd_ready: got %b want 0", cmd_ready); end
        tick;
        tick;
        cmd_valid = 1'b0;
        cmd = CMD_NOP;
        vecs++; if (load_ready !== 1'b1) begin errs++; $display("FAIL busy_still_load: got %b want 1", load_ready); end
        for (int i = 4; i >= 0; i--) begin
            load_valid = 1'b1;
            load_data = pat[i];
            tick;
        end
        load_valid = 1'b0;
        tick;
        tick;
        vecs++; if (rm_n - rm0 != 0) begin errs++; $display("FAIL busy_cmd_run_cycles: got %0d want 0", rm_n - rm0); end
        vecs++; if (mem !== 5'b10011) begin errs++; $display("FAIL busy_load_mem: got %b want 10011", mem); end
        vecs++; if (done_n - d0 != 1) begin errs++; $display("FAIL busy_load_done: got %0d want 1", done_n - d0); end
    endtask

    task automatic test_abort;
        int lm0;
        int d0;
        lm0 = lm_n;
        d0 = done_n;
        send_cmd(CMD_LOAD);
        load_valid = 1'b1;
        load_data = 1'b1;
        tick;
        tick;
        abort = 1'b1;
        #1;
        vecs++; if (load_mode !== 1'b0) begin errs++; $display("FAIL abort_mode_drop: got %b want 0", load_mode); end
        tick;
        abort = 1'b0;
        load_valid = 1'b0;
        vecs++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errs++; $display("FAIL abort_idle: got busy=%b ready=%b want busy=0 ready=1", busy, cmd_ready); end
        tick;
        tick;
        tick;
        vecs++; if (lm_n - lm0 != 2) begin errs++; $display("FAIL abort_load_cycles: got %0d want 2", lm_n - lm0); end
        vecs++; if (done_n - d0 != 0) begin errs++; $display("FAIL abort_done: got %0d want 0", done_n - d0); end
    endtask

    task automatic test_abort_idle;
        int rm0;
        int d0;
        int c;
        rm0 = rm_n;
        d0 = done_n;
        generations = 8'd2;
        abort = 1'b1;
        send_cmd(CMD_RUN);
        abort = 1'b0;
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL abort_idle_accept: got busy=%b want 1", busy); end
        c = 0;
        while (done_n == d0 && c < 20) begin
            tick;
            c++;
        end
        tick;
        vecs++; if (rm_n - rm0 != 2) begin errs++; $display("FAIL abort_idle_run_cycles: got %0d want 2", rm_n - rm0); end
        vecs++; if (done_n - d0 != 1) begin errs++; $display("FAIL abort_idle_done: got %0d want 1", done_n - d0); end
    endtask

    task automatic test_load_valid_idle;
        int lm0;
        lm0 = lm_n;
        load_valid = 1'b1;
        load_data = 1'b1;
        tick;
        tick;
        tick;
        load_valid = 1'b0;
        vecs++; if (lm_n - lm0 != 0) begin errs++; $display("FAIL idle_load_valid: got %0d load cycles want 0", lm_n - lm0); end
        vecs++; if (mem !== 5'b10011) begin errs++; $display("FAIL idle_load_mem: got %b want 10011", mem); end
    endtask

    task automatic test_reset_mid_run;
        generations = 8'd50;
        send_cmd(CMD_RUN);
        tick;
        tick;
        vecs++; if (run_mode !== 1'b1) begin errs++; $display("FAIL midrun_running: got %b want 1", run_mode); end
        rst_n = 1'b0;
        #1;
        vecs++; if (run_mode !== 1'b0) begin errs++; $display("FAIL midrun_reset_mode: got %b want 0", run_mode); end
        vecs++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errs++; $display("FAIL midrun_reset_idle: got busy=%b ready=%b want busy=0 ready=1", busy, cmd_ready); end
        tick;
        rst_n = 1'b1;
        tick;
        vecs++; if (busy !== 1'b0 || run_mode !== 1'b0) begin errs++; $display("FAIL midrun_after_release: got busy=%b run=%b want 0 0", busy, run_mode); end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd = CMD_NOP;
        cmd_valid = 1'b0;
        generations = 8'd0;
        abort = 1'b0;
        load_data = 1'b0;
        load_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        test_reset;
        tick;
        rst_n = 1'b1;
        tick;
        test_load;
        test_output(1'b0);
        test_output(1'b1);
        test_run(3);
        test_run(0);
        test_cmd_during_load;
        test_load_valid_idle;
        test_abort;
        test_abort_idle;
        test_reset_mid_run;
        vecs++; if (overlap_n != 0) begin errs++; $display("FAIL mode_overlap: got %0d cycles want 0", overlap_n); end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
